// File: rtl/display_timings_prog.sv
// Programmable display timing generator: every output is registered one cycle after internal x/y.
// Modes enter a one-deep shadow via valid/ready (ready low while a mode is pending) and apply only at the frame wrap.
module display_timings_prog #(
    parameter int CORDW  = 16,
    parameter int H_RES  = 1280,
    parameter int H_FP   = 110,
    parameter int H_SYNC = 40,
    parameter int H_BP   = 220,
    parameter int V_RES  = 720,
    parameter int V_FP   = 5,
    parameter int V_SYNC = 5,
    parameter int V_BP   = 20,
    parameter int H_POL  = 1,
    parameter int V_POL  = 1
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CORDW-2:0]        cfg_h_res,
    input  logic [CORDW-2:0]        cfg_h_fp,
    input  logic [CORDW-2:0]        cfg_h_sync,
    input  logic [CORDW-2:0]        cfg_h_bp,
    input  logic [CORDW-2:0]        cfg_v_res,
    input  logic [CORDW-2:0]        cfg_v_fp,
    input  logic [CORDW-2:0]        cfg_v_sync,
    input  logic [CORDW-2:0]        cfg_v_bp,
    input  logic                    cfg_h_pol,
    input  logic                    cfg_v_pol,
    output logic                    cfg_err,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy
);

    typedef logic [CORDW-2:0]        fld_t;
    typedef logic signed [CORDW-1:0] crd_t;

    typedef struct packed {
        fld_t h_res;
        fld_t h_fp;
        fld_t h_sync;
        fld_t h_bp;
        fld_t v_res;
        fld_t v_fp;
        fld_t v_sync;
        fld_t v_bp;
        logic h_pol;
        logic v_pol;
    } mode_t;

    typedef struct packed {
        crd_t h_sta;
        crd_t hs_sta;
        crd_t hs_end;
        crd_t ha_end;
        crd_t v_sta;
        crd_t vs_sta;
        crd_t vs_end;
        crd_t va_end;
    } tim_t;

    function automatic crd_t zx(input fld_t f);
        return $signed({1'b0, f});
    endfunction

    function automatic tim_t derive(input mode_t m);
        tim_t t;
        t.h_sta  = -(zx(m.h_fp) + zx(m.h_sync) + zx(m.h_bp));
        t.hs_sta = t.h_sta + zx(m.h_fp);
        t.hs_end = t.hs_sta + zx(m.h_sync);
        t.ha_end = zx(m.h_res) - crd_t'(1);
        t.v_sta  = -(zx(m.v_fp) + zx(m.v_sync) + zx(m.v_bp));
        t.vs_sta = t.v_sta + zx(m.v_fp);
        t.vs_end = t.vs_sta + zx(m.v_sync);
        t.va_end = zx(m.v_res) - crd_t'(1);
        return t;
    endfunction

    // The blanking sum must stay representable so that -(fp+sync+bp) is a valid negative start.
    function automatic logic mode_ok(input mode_t m);
        crd_t hsum;
        crd_t vsum;
        hsum = zx(m.h_fp) + zx(m.h_sync) + zx(m.h_bp);
        vsum = zx(m.v_fp) + zx(m.v_sync) + zx(m.v_bp);
        return (m.h_res != '0) && (m.v_res != '0) &&
               (m.h_sync != '0) && (m.v_sync != '0) &&
               !hsum[CORDW-1] && !vsum[CORDW-1];
    endfunction

    localparam mode_t DEF_MODE = '{
        h_res:  fld_t'(H_RES),  h_fp: fld_t'(H_FP), h_sync: fld_t'(H_SYNC), h_bp: fld_t'(H_BP),
        v_res:  fld_t'(V_RES),  v_fp: fld_t'(V_FP), v_sync: fld_t'(V_SYNC), v_bp: fld_t'(V_BP),
        h_pol:  1'(H_POL),      v_pol: 1'(V_POL)
    };
    localparam tim_t DEF_TIM = derive(DEF_MODE);

    mode_t mode_q, mode_d, shadow_q, shadow_d, cfg_mode;
    tim_t  tim_q, tim_d;
    logic  pending_q, pending_d;
    crd_t  x_q, x_d, y_q, y_d;
    crd_t  sx_q, sx_d, sy_q, sy_d;
    logic  de_q, de_d, frame_q, frame_d, line_q, line_d;
    logic  hsync_q, hsync_d, vsync_q, vsync_d, cfg_err_q, cfg_err_d;
    logic  xfer, cfg_good, h_end, wrap, apply, hs_in, vs_in;

    always_comb begin
        cfg_mode.h_res  = cfg_h_res;
        cfg_mode.h_fp   = cfg_h_fp;
        cfg_mode.h_sync = cfg_h_sync;
        cfg_mode.h_bp   = cfg_h_bp;
        cfg_mode.v_res  = cfg_v_res;
        cfg_mode.v_fp   = cfg_v_fp;
        cfg_mode.v_sync = cfg_v_sync;
        cfg_mode.v_bp   = cfg_v_bp;
        cfg_mode.h_pol  = cfg_h_pol;
        cfg_mode.v_pol  = cfg_v_pol;

        xfer     = cfg_valid && !pending_q;
        cfg_good = mode_ok(cfg_mode);
        h_end    = (x_q == tim_q.ha_end);
        wrap     = h_end && (y_q == tim_q.va_end);
        apply    = wrap && pending_q;

        mode_d    = mode_q;
        tim_d     = tim_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        cfg_err_d = xfer && !cfg_good;

        if (xfer && cfg_good) begin
            shadow_d  = cfg_mode;
            pending_d = 1'b1;
        end

        // Applying swaps mode and counters together so the new frame starts cleanly at its own H_STA/V_STA.
        if (apply) begin
            mode_d    = shadow_q;
            tim_d     = derive(shadow_q);
            pending_d = 1'b0;
            x_d       = tim_d.h_sta;
            y_d       = tim_d.v_sta;
        end else if (h_end) begin
            x_d = tim_q.h_sta;
            y_d = wrap ? tim_q.v_sta : y_q + crd_t'(1);
        end else begin
            x_d = x_q + crd_t'(1);
            y_d = y_q;
        end

        hs_in   = (x_q >= tim_q.hs_sta) && (x_q < tim_q.hs_end);
        vs_in   = (y_q >= tim_q.vs_sta) && (y_q < tim_q.vs_end);
        hsync_d = mode_q.h_pol ? hs_in : ~hs_in;
        vsync_d = mode_q.v_pol ? vs_in : ~vs_in;
        de_d    = (y_q >= 0) && (x_q >= 0);
        frame_d = (x_q == tim_q.h_sta) && (y_q == tim_q.v_sta);
        line_d  = (x_q == tim_q.h_sta);
        sx_d    = x_q;
        sy_d    = y_q;
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            mode_q    <= DEF_MODE;
            tim_q     <= DEF_TIM;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            x_q       <= DEF_TIM.h_sta;
            y_q       <= DEF_TIM.v_sta;
            sx_q      <= DEF_TIM.h_sta;
            sy_q      <= DEF_TIM.v_sta;
            de_q      <= 1'b0;
            frame_q   <= 1'b0;
            line_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            hsync_q   <= ~DEF_MODE.h_pol;
            vsync_q   <= ~DEF_MODE.v_pol;
        end else begin
            mode_q    <= mode_d;
            tim_q     <= tim_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            x_q       <= x_d;
            y_q       <= y_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            de_q      <= de_d;
            frame_q   <= frame_d;
            line_q    <= line_d;
            cfg_err_q <= cfg_err_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    assign cfg_ready = ~pending_q;
    assign cfg_err   = cfg_err_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign frame     = frame_q;
    assign line      = line_q;
    assign sx        = sx_q;
    assign sy        = sy_q;

endmodule

// File: doc/display_timings_prog.md
Name: display_timings_prog

Overview:
Runtime-programmable display timing generator. It is the successor to the fixed-mode display controllers, with every horizontal and vertical timing field and both sync polarities loadable at run time. A new mode is accepted through a valid/ready handshake into a shadow register and takes effect only at a frame boundary, so no frame is ever torn. It sits in the pixel clock domain and feeds the same downstream consumers: sx/sy, de, frame, line, hsync and vsync.

Parameters:
CORDW, 16, signed coordinate width in bits; cfg fields are CORDW-1 bits unsigned.
H_RES, 1280, reset-default horizontal active pixels.
H_FP, 110, reset-default horizontal front porch.
H_SYNC, 40, reset-default horizontal sync width.
H_BP, 220, reset-default horizontal back porch.
V_RES, 720, reset-default vertical active lines.
V_FP, 5, reset-default vertical front porch.
V_SYNC, 5, reset-default vertical sync width.
V_BP, 20, reset-default vertical back porch.
H_POL, 1, reset-default hsync polarity (0: neg, 1: pos).
V_POL, 1, reset-default vsync polarity (0: neg, 1: pos).

Ports:
clk_pix  in  1  pixel clock
rst_pix_n  in  1  asynchronous active-low reset
cfg_valid  in  1  new mode offered
cfg_ready  out  1  shadow register empty, can accept a mode
cfg_h_res, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CORDW-1 each  horizontal fields
cfg_v_res, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CORDW-1 each  vertical fields
cfg_h_pol, cfg_v_pol  in  1 each  sync polarities
cfg_err  out  1  one-cycle pulse when an offered mode is rejected
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable
frame  out  1  one-cycle pulse at start of frame
line  out  1  one-cycle pulse at start of line
sx  out  CORDW signed  horizontal position
sy  out  CORDW signed  vertical position

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low (rst_pix_n).
  - Active mode loads the parameter defaults; shadow is cleared, pending=0.
  - Internal x/y = default H_STA/V_STA; sx/sy = default H_STA/V_STA.
  - de=frame=line=cfg_err=0; hsync/vsync at the inactive level of the default polarity; cfg_ready=1.
- Derived values are registered from the active mode:
  - H_STA = -(fp+sync+bp); HS_STA = H_STA+fp; HS_END = HS_STA+sync; HA_END = res-1.
  - Vertical values are derived the same way.
- Counting:
  - x increments each cycle; when x==HA_END, x goes to H_STA.
  - y increments when x wraps; when x==HA_END and y==VA_END (the wrap cycle), y goes to V_STA.
- Outputs are registered, with one cycle of latency from internal x/y:
  - de = (y>=0 && x>=0); frame = (x==H_STA && y==V_STA); line = (x==H_STA).
  - hsync = pol ? inside : ~inside, where inside = HS_STA<=x<HS_END; vsync is the same on y.
  - sx/sy are the delayed x/y.
- Handshake:
  - cfg_ready = ~pending. A transfer happens when cfg_valid && cfg_ready.
  - A valid transfer copies all fields into the shadow register and sets pending=1; cfg_ready drops on the next cycle.
  - Fields are sampled only on the transfer cycle.
- Validation at transfer:
  - Reject if any res==0 or any sync==0, or if fp+sync+bp (computed CORDW bits wide) >= 2^(CORDW-1).
  - A rejected transfer leaves the shadow untouched, keeps pending=0 and pulses cfg_err on the next cycle.
- Apply:
  - On the wrap cycle with pending=1, the active mode is loaded from the shadow and pending is cleared.
  - x/y load the new H_STA/V_STA in that same cycle, so the next frame pulse and every output of the new frame use the new mode, including polarity.
- Simultaneous events:
  - A transfer in a wrap cycle while pending=0 is captured, but applied only at the following wrap.
  - An apply frees the slot; cfg_ready rises on the cycle after the apply.
- Reset mid-operation (including while pending=1): the shadow is discarded and the defaults are restored immediately.
- Arithmetic: all comparisons are signed, CORDW bits; unsigned cfg fields are zero-extended.

Test Plan:
1. Parameters H_RES=8, H_FP=2, H_SYNC=3, H_BP=1, V_RES=4, V_FP=1, V_SYNC=2, V_BP=1, H_POL=V_POL=1; release reset -> 14-cycle line, 112-cycle frame; sx runs -6..7; hsync high for sx -4..-2; vsync high for sy -3..-2; de high for 32 cycles per frame.
2. Offer h_res=4 mid-frame with the other fields unchanged -> cfg_ready=0 the next cycle; the current frame stays 112 cycles; after the next frame pulse, the line is 10 cycles and the frame is 80 cycles; cfg_ready=1 the cycle after the apply.
3. Offer h_sync=0 -> cfg_err pulses once; cfg_ready stays 1; timing is unchanged.
4. Offer a mode in exactly the wrap cycle -> the mode is not applied at that wrap; it is applied at the following wrap.
5. Change polarity to h_pol=0 -> hsync idles high and goes low for exactly 3 cycles per line, starting in the new frame only.
6. Assert rst_pix_n low with pending=1, mid-line -> outputs go to reset values asynchronously; after release, default timing resumes and the shadow mode is never applied.
